// File: rtl/cpu_pkg.sv
// Definitions shared by the control unit, the fetch responder and the decoder:
// default widths, fetch FSM state codes and the instruction word type.
package cpu_pkg;

  localparam int CPU_ADDR_W = 2;
  localparam int CPU_DATA_W = 8;

  // Fetch FSM encoding; 2'b11 is unreachable and falls back to idle.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  typedef logic [CPU_DATA_W-1:0] instr_t;

endpackage

// File: rtl/fetch_prog_store.sv
// Small loadable program store: DEPTH words, synchronous write, synchronous
// clear on reset, registered read. Reads and writes outside DEPTH are inert:
// writes are dropped, reads return 0.
module fetch_prog_store
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DATA_W-1:0]            rd_mux;

  // Read mux; an address with no matching entry reads as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < DEPTH; i++)
      if (32'(rd_addr) == i) rd_mux = mem[i];
  end

  // Store update and registered read. The read samples mem before any write
  // on the same edge, so a same-address write is not visible yet.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem     <= '0;
      rd_data <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_en && 32'(wr_addr) == i) mem[i] <= wr_data;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: rtl/instr_fetch_responder.sv
// Responder end of the control-unit fetch interface. Accepts a pc over a
// valid/ready handshake, waits WAIT_CYCLES, then presents the instruction word
// from the program store until the control unit takes it. One fetch in flight;
// every output comes straight from a register.
module instr_fetch_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = CPU_ADDR_W,
  parameter int DATA_W      = CPU_DATA_W,
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy
);

  localparam logic [31:0] DEPTH_U   = 32'(DEPTH);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] store_q;

  // The store read fires on the edge that moves the FSM into RESP. With no
  // wait states that is the accept edge itself, so read the live request.
  always_comb begin
    accept     = (state == ST_IDLE) && req_valid && req_ready;
    enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                 ((state == ST_WAIT) && (cnt == 4'd0));
    rd_addr    = (state == ST_IDLE) ? req_addr : addr_q;
  end

  fetch_prog_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (enter_resp),
    .rd_addr (rd_addr),
    .rd_data (store_q)
  );

  // Fetch FSM with its wait counter and handshake output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // req_ready comes up one cycle after reset release.
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (accept) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          // First RESP cycle copies the sampled word out; then hold until taken.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= store_q;
            rsp_err   <= (32'(addr_q) >= DEPTH_U);
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Bench for instr_fetch_responder. Three instances (different DEPTH and
// WAIT_CYCLES) share one input stream; a transaction-level model predicts
// every output each cycle, and directed fetches pin known words and latencies.
module tb_instr_fetch_responder;

  localparam int N = 3;
  localparam int DEPS [N] = '{4, 3, 4};
  localparam int WCS  [N] = '{1, 3, 0};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic rsp_ready = 1'b0;
  logic load_en = 1'b0;
  logic [1:0] req_addr = '0;
  logic [1:0] load_addr = '0;
  logic [7:0] load_data = '0;

  logic [N-1:0]      rr, rv, re, bz;
  logic [N-1:0][7:0] rd;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    instr_fetch_responder #(
      .ADDR_W(2), .DATA_W(8), .DEPTH(DEPS[g]), .WAIT_CYCLES(WCS[g])
    ) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(rr[g]),
      .rsp_valid(rv[g]), .rsp_ready(rsp_ready), .rsp_data(rd[g]), .rsp_err(re[g]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(bz[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: timing counted in edges since the accept edge. Word and error are
  // sampled WAIT_CYCLES edges after accept (before that edge's load) and shown
  // one edge later, held until rsp_ready.
  int m_store [N][4];
  bit m_busy [N], m_ready [N], m_valid [N], m_err [N], s_err [N];
  int m_data [N], s_data [N], m_t [N], m_addr [N];

  task automatic snap(input int d);
    s_err[d]  = (m_addr[d] >= DEPS[d]);
    s_data[d] = s_err[d] ? 0 : m_store[d][m_addr[d]];
  endtask

  task automatic model_step();
    for (int d = 0; d < N; d++) begin
      if (!reset) begin
        m_busy[d] = 0; m_ready[d] = 0; m_valid[d] = 0; m_err[d] = 0;
        m_data[d] = 0; m_t[d] = 0;
        for (int a = 0; a < 4; a++) m_store[d][a] = 0;
      end else begin
        if (m_valid[d]) begin
          if (rsp_ready) begin
            m_valid[d] = 0; m_err[d] = 0; m_busy[d] = 0; m_ready[d] = 1;
          end
        end else if (m_busy[d]) begin
          m_t[d]++;
          if (m_t[d] == WCS[d]) snap(d);
          if (m_t[d] == WCS[d] + 1) begin
            m_valid[d] = 1; m_data[d] = s_data[d]; m_err[d] = s_err[d];
          end
        end else if (!m_ready[d]) begin
          m_ready[d] = 1;
        end else if (req_valid) begin
          m_ready[d] = 0; m_busy[d] = 1; m_addr[d] = int'(req_addr); m_t[d] = 0;
          if (WCS[d] == 0) snap(d);
        end
        if (load_en && int'(load_addr) < DEPS[d]) m_store[d][load_addr] = int'(load_data);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compare every output against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      for (int d = 0; d < N; d++) begin
        chk($sformatf("d%0d.req_ready", d), 32'(rr[d]), 32'(m_ready[d]));
        chk($sformatf("d%0d.rsp_valid", d), 32'(rv[d]), 32'(m_valid[d]));
        chk($sformatf("d%0d.busy", d),      32'(bz[d]), 32'(m_busy[d]));
        chk($sformatf("d%0d.rsp_err", d),   32'(re[d]), 32'(m_err[d]));
        if (m_valid[d]) chk($sformatf("d%0d.rsp_data", d), 32'(rd[d]), 32'(m_data[d]));
      end
    end
  end

  logic [31:0] got [N], gerr [N], lat [N];

  task automatic load(input logic [1:0] a, input logic [7:0] v);
    load_en = 1; load_addr = a; load_data = v;
    cyc();
    load_en = 0;
  endtask

  // One fetch on all instances; optional backpressure and a load timed
  // ld_off edges after the accept edge. Records first word/err/latency.
  task automatic fetch(input logic [1:0] a, input bit bp, input int ld_off,
                       input logic [1:0] la, input logic [7:0] ldv);
    bit seen [N];
    bit done, all_seen;
    int bpn;
    for (int d = 0; d < N; d++) begin
      seen[d] = 0; lat[d] = '1; got[d] = '1; gerr[d] = '1;
    end
    req_valid = 1; req_addr = a; rsp_ready = !bp;
    load_en = (ld_off == 0); load_addr = la; load_data = ldv;
    cyc();
    req_valid = bp;
    if (bp) req_addr = 2'd3;
    bpn = 0; done = 0;
    for (int k = 1; k <= 60 && !done; k++) begin
      load_en = (k == ld_off);
      cyc();
      all_seen = 1; done = 1;
      for (int d = 0; d < N; d++) begin
        if (!seen[d] && rv[d]) begin
          seen[d] = 1; lat[d] = 32'(k); got[d] = 32'(rd[d]); gerr[d] = 32'(re[d]);
        end
        if (!seen[d]) all_seen = 0;
        if (!seen[d] || !rr[d]) done = 0;
      end
      if (bp && !rsp_ready && all_seen) begin
        bpn++;
        if (bpn == 5) begin rsp_ready = 1; req_valid = 0; end
      end
    end
    load_en = 0; req_valid = 0; rsp_ready = 1;
    chk("fetch_done", 32'(done), 32'd1);
  endtask

  task automatic check_fetch(input string nm, input logic [7:0] d0, d1, d2,
                             input logic e0, e1, e2);
    logic [7:0] ed [N];
    logic       ee [N];
    ed[0] = d0; ed[1] = d1; ed[2] = d2;
    ee[0] = e0; ee[1] = e1; ee[2] = e2;
    for (int d = 0; d < N; d++) begin
      chk($sformatf("%s.d%0d.data", nm, d), got[d], 32'(ed[d]));
      chk($sformatf("%s.d%0d.err", nm, d), gerr[d], 32'(ee[d]));
      chk($sformatf("%s.d%0d.lat", nm, d), lat[d], 32'(WCS[d] + 1));
    end
  endtask

  initial begin
    int rst_left;

    // Reset held with a pending request: everything stays zero.
    reset = 0; req_valid = 1; req_addr = 2'd1;
    repeat (3) begin
      cyc();
      chk_on = 1;
      for (int d = 0; d < N; d++) begin
        chk($sformatf("rst.d%0d.req_ready", d), 32'(rr[d]), 0);
        chk($sformatf("rst.d%0d.rsp_valid", d), 32'(rv[d]), 0);
        chk($sformatf("rst.d%0d.rsp_data", d),  32'(rd[d]), 0);
        chk($sformatf("rst.d%0d.rsp_err", d),   32'(re[d]), 0);
        chk($sformatf("rst.d%0d.busy", d),      32'(bz[d]), 0);
      end
    end
    reset = 1; req_valid = 0;
    cyc();
    for (int d = 0; d < N; d++) chk($sformatf("rel.d%0d.req_ready", d), 32'(rr[d]), 1);

    // Basic fetch.
    load(2'd0, 8'hA1); load(2'd1, 8'hB2); load(2'd2, 8'hC3); load(2'd3, 8'hD4);
    fetch(2'd2, 0, -1, 2'd0, 8'h00);
    check_fetch("basic", 8'hC3, 8'hC3, 8'hC3, 0, 0, 0);

    // Backpressure with a competing request held during the busy period.
    fetch(2'd1, 1, -1, 2'd0, 8'h00);
    check_fetch("bp", 8'hB2, 8'hB2, 8'hB2, 0, 0, 0);

    // Address 3 is out of range only on the DEPTH=3 instance.
    fetch(2'd3, 0, -1, 2'd0, 8'h00);
    check_fetch("oor", 8'hD4, 8'h00, 8'hD4, 0, 1, 0);
    fetch(2'd0, 0, -1, 2'd0, 8'h00);
    check_fetch("after_oor", 8'hA1, 8'hA1, 8'hA1, 0, 0, 0);

    // Load of 0x55 to addr 2 one edge after accept: that is RESP entry for
    // WAIT_CYCLES=1 (hidden), after entry for 0 (hidden), before entry for 3.
    fetch(2'd2, 0, 1, 2'd2, 8'h55);
    check_fetch("collide", 8'hC3, 8'h55, 8'hC3, 0, 0, 0);
    fetch(2'd2, 0, -1, 2'd0, 8'h00);
    check_fetch("refetch", 8'h55, 8'h55, 8'h55, 0, 0, 0);

    // Reset during the wait period drops the fetch and clears the store.
    req_valid = 1; req_addr = 2'd0;
    cyc();
    req_valid = 0; reset = 0;
    cyc(); cyc();
    reset = 1;
    repeat (8) begin
      cyc();
      for (int d = 0; d < N; d++) chk($sformatf("abort.d%0d.rsp_valid", d), 32'(rv[d]), 0);
    end
    fetch(2'd0, 0, -1, 2'd0, 8'h00);
    check_fetch("cleared", 8'h00, 8'h00, 8'h00, 0, 0, 0);
    load(2'd0, 8'hA1); load(2'd1, 8'hB2); load(2'd2, 8'hC3); load(2'd3, 8'hD4);
    fetch(2'd2, 0, -1, 2'd0, 8'h00);
    check_fetch("reload", 8'hC3, 8'hC3, 8'hC3, 0, 0, 0);

    // Random traffic with occasional resets, checked by the model each cycle.
    rst_left = 0;
    for (int c = 0; c < 2000; c++) begin
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 199) == 0) rst_left = $urandom_range(1, 3);
      reset     = (rst_left == 0);
      req_valid = ($urandom_range(0, 1) == 1);
      req_addr  = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      load_en   = ($urandom_range(0, 3) == 0);
      load_addr = 2'($urandom_range(0, 3));
      load_data = 8'($urandom_range(0, 255));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
